// File: rtl/la_trace_decoder_if.sv
// la_trace_decoder_if: packet stream in and expanded sample stream out.
// Revision: 1.0
`default_nettype none

interface la_trace_decoder_if #(
  parameter int pDATA_WIDTH = 32,
  parameter int pSIG_WIDTH  = 24
);
  logic [pDATA_WIDTH-1:0] s_tdata;
  logic                   s_tvalid;
  logic                   s_tready;
  logic                   s_tlast;
  logic [1:0]             s_tuser;
  logic [pSIG_WIDTH-1:0]  out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_first;
  logic                   out_gap;
  logic                   out_last;
  logic [1:0]             out_tuser;

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, s_tuser, out_ready,
    output s_tready, out_data, out_valid, out_first, out_gap, out_last, out_tuser
  );

  modport master (
    output s_tdata, s_tvalid, s_tlast, s_tuser, out_ready,
    input  s_tready, out_data, out_valid, out_first, out_gap, out_last, out_tuser
  );
endinterface

`default_nettype wire

// File: rtl/la_trace_decoder.sv
// ---------------------------------------------------------------------------
// la_trace_decoder: expands run-length-encoded LA packets {rc, signals} into
// a per-cycle signal trace; optional repeat checker under LA_DEC_CHECK_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module la_trace_decoder #(
  parameter int pDATA_WIDTH = 32,
  parameter int pSIG_WIDTH  = 24,
  parameter int pOVF_CNT_W  = 16
) (
  input  logic                  axi_clk,
  input  logic                  axi_reset_n,
  input  logic                  dec_clear,
  la_trace_decoder_if.slave     bus,
  output logic                  ovf_flag,
  output logic [pOVF_CNT_W-1:0] ovf_count
`ifdef LA_DEC_CHECK_EN
  ,
  output logic                  err_repeat,
  output logic [7:0]            err_count
`endif
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] EXPAND = 1'b1;

  logic [0:0]            r_state;
  logic [7:0]            r_rem;
  logic [pSIG_WIDTH-1:0] r_data;
  logic                  r_first;
  logic                  r_gap;
  logic                  r_tlast;
  logic [1:0]            r_tuser;
  logic                  r_gap_pend;
  logic                  r_ovf_flag;
  logic [pOVF_CNT_W-1:0] r_ovf_count;

  logic [7:0]            w_rc;
  logic [pSIG_WIDTH-1:0] w_sig;
  logic                  w_accept;
  logic                  w_load;
  logic                  w_marker;
  logic                  w_hs;

  assign w_rc     = bus.s_tdata[pDATA_WIDTH-1 -: 8];
  assign w_sig    = bus.s_tdata[pSIG_WIDTH-1:0];
  assign w_hs     = (r_state == EXPAND) && bus.out_ready;
  // Ready looks through out_ready so the next packet loads as the last sample leaves.
  assign bus.s_tready = axi_reset_n && !dec_clear &&
                        ((r_state == IDLE) || (bus.out_ready && (r_rem == 8'd1)));
  assign w_accept = bus.s_tvalid && bus.s_tready;
  assign w_load   = w_accept && (w_rc != 8'd0);
  assign w_marker = w_accept && (w_rc == 8'd0);

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      r_state     <= IDLE;
      r_rem       <= 8'd0;
      r_data      <= '0;
      r_first     <= 1'b0;
      r_gap       <= 1'b0;
      r_tlast     <= 1'b0;
      r_tuser     <= 2'b00;
      r_gap_pend  <= 1'b0;
      r_ovf_flag  <= 1'b0;
      r_ovf_count <= '0;
    end else if (dec_clear) begin
      r_state     <= IDLE;
      r_rem       <= 8'd0;
      r_data      <= '0;
      r_first     <= 1'b0;
      r_gap       <= 1'b0;
      r_tlast     <= 1'b0;
      r_tuser     <= 2'b00;
      r_gap_pend  <= 1'b0;
      r_ovf_flag  <= 1'b0;
      r_ovf_count <= '0;
    end else begin
      if (w_load) begin
        r_state    <= EXPAND;
        r_rem      <= w_rc;
        r_data     <= w_sig;
        r_first    <= 1'b1;
        r_gap      <= r_gap_pend;
        r_tlast    <= bus.s_tlast;
        r_tuser    <= bus.s_tuser;
        r_gap_pend <= 1'b0;
      end else if (w_hs) begin
        r_rem   <= r_rem - 8'd1;
        r_first <= 1'b0;
        r_gap   <= 1'b0;
        if (r_rem == 8'd1) begin
          r_state <= IDLE;
        end
      end
      if (w_marker) begin
        r_gap_pend <= 1'b1;
        r_ovf_flag <= 1'b1;
        if (r_ovf_count != {pOVF_CNT_W{1'b1}}) begin
          r_ovf_count <= r_ovf_count + 1'b1;
        end
      end
    end
  end

  assign bus.out_valid = (r_state == EXPAND);
  assign bus.out_data  = r_data;
  assign bus.out_first = r_first;
  assign bus.out_gap   = r_gap;
  assign bus.out_last  = r_tlast && (r_rem == 8'd1);
  assign bus.out_tuser = r_tuser;
  assign ovf_flag      = r_ovf_flag;
  assign ovf_count     = r_ovf_count;

`ifdef LA_DEC_CHECK_EN
  logic [pSIG_WIDTH-1:0] r_prev_sig;
  logic                  r_prev_vld;
  logic                  r_err;
  logic [7:0]            r_err_cnt;

  // An unbroken repeat of the same signals should have been merged upstream.
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      r_prev_sig <= '0;
      r_prev_vld <= 1'b0;
      r_err      <= 1'b0;
      r_err_cnt  <= 8'd0;
    end else if (dec_clear) begin
      r_prev_sig <= '0;
      r_prev_vld <= 1'b0;
      r_err      <= 1'b0;
      r_err_cnt  <= 8'd0;
    end else if (w_load) begin
      r_prev_sig <= w_sig;
      r_prev_vld <= 1'b1;
      if (r_prev_vld && (w_sig == r_prev_sig) && !r_gap_pend) begin
        r_err <= 1'b1;
        if (r_err_cnt != 8'hFF) begin
          r_err_cnt <= r_err_cnt + 8'd1;
        end
      end
    end
  end

  assign err_repeat = r_err;
  assign err_count  = r_err_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_la_trace_decoder.sv
// tb_la_trace_decoder: directed plus randomized checks of la_trace_decoder
// against a queue-based expansion model.
`default_nettype none

module tb_la_trace_decoder;

  typedef struct packed {
    logic [23:0] d;
    logic        f;
    logic        g;
    logic        l;
    logic [1:0]  u;
  } smp_t;

  logic        axi_clk = 1'b0;
  logic        axi_reset_n = 1'b0;
  logic        dec_clear = 1'b0;
  logic        ovf_flag;
  logic [15:0] ovf_count;
  logic        man_rdy = 1'b1;
  logic        rnd_rdy = 1'b1;
  bit          rdy_rand = 1'b0;
`ifdef LA_DEC_CHECK_EN
  logic        err_repeat;
  logic [7:0]  err_count;
`endif

  int total = 0;
  int bad = 0;

  smp_t q[$];
  smp_t hs_log[$];
  smp_t held;
  bit   hold_chk = 1'b0;
  bit   m_gap = 1'b0;
  bit   m_flag = 1'b0;
  int   m_cnt = 0;

  la_trace_decoder_if dif ();

  la_trace_decoder dut (
    .axi_clk     (axi_clk),
    .axi_reset_n (axi_reset_n),
    .dec_clear   (dec_clear),
    .bus         (dif),
    .ovf_flag    (ovf_flag),
    .ovf_count   (ovf_count)
`ifdef LA_DEC_CHECK_EN
    ,
    .err_repeat  (err_repeat),
    .err_count   (err_count)
`endif
  );

  always #5 axi_clk = ~axi_clk;

  assign dif.out_ready = rdy_rand ? rnd_rdy : man_rdy;

  always @(posedge axi_clk) begin
    #1 rnd_rdy = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: each accepted packet becomes rc queued samples; markers only touch counters.
  always @(negedge axi_clk) begin
    smp_t cur;
    smp_t s;
    logic exp_rdy;
    int   rc;
    cur = {dif.out_data, dif.out_first, dif.out_gap, dif.out_last, dif.out_tuser};
    if (!axi_reset_n) begin
      q.delete();
      m_gap = 1'b0; m_flag = 1'b0; m_cnt = 0; hold_chk = 1'b0;
      chk("rst_valid", {31'd0, dif.out_valid}, 32'd0);
      chk("rst_tready", {31'd0, dif.s_tready}, 32'd0);
      chk("rst_ovf", {16'd0, ovf_count}, 32'd0);
    end else begin
      exp_rdy = !dec_clear && ((q.size() == 0) || (dif.out_ready && (q.size() == 1)));
      chk("valid", {31'd0, dif.out_valid}, {31'd0, (q.size() != 0)});
      chk("tready", {31'd0, dif.s_tready}, {31'd0, exp_rdy});
      chk("ovf_count", {16'd0, ovf_count}, m_cnt);
      chk("ovf_flag", {31'd0, ovf_flag}, {31'd0, m_flag});
      if (q.size() != 0) chk("sample", {3'd0, cur}, {3'd0, q[0]});
      if (hold_chk) chk("hold", {3'd0, cur}, {3'd0, held});
      hold_chk = dif.out_valid && !dif.out_ready && !dec_clear;
      held = cur;
      if (dec_clear) begin
        q.delete();
        m_gap = 1'b0; m_flag = 1'b0; m_cnt = 0;
      end else begin
        if (dif.out_valid && dif.out_ready) begin
          hs_log.push_back(cur);
          if (q.size() != 0) void'(q.pop_front());
        end
        if (dif.s_tvalid && dif.s_tready) begin
          rc = int'(dif.s_tdata[31:24]);
          if (rc == 0) begin
            m_gap = 1'b1;
            m_flag = 1'b1;
            if (m_cnt < 65535) m_cnt++;
          end else begin
            for (int i = 0; i < rc; i++) begin
              s.d = dif.s_tdata[23:0];
              s.f = (i == 0);
              s.g = (i == 0) && m_gap;
              s.l = dif.s_tlast && (i == rc - 1);
              s.u = dif.s_tuser;
              q.push_back(s);
            end
            m_gap = 1'b0;
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] rc, input logic [23:0] sig,
                      input logic tl, input logic [1:0] user);
    int n;
    n = 0;
    dif.s_tdata  = {rc, sig};
    dif.s_tlast  = tl;
    dif.s_tuser  = user;
    dif.s_tvalid = 1'b1;
    do begin
      @(negedge axi_clk);
      n++;
    end while (!dif.s_tready && n < 2000);
    if (n >= 2000) chk("send_timeout", 32'd0, 32'd1);
    @(posedge axi_clk);
    #1 dif.s_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (dif.out_valid && n < 2000) begin
      @(posedge axi_clk);
      #1 n++;
    end
    if (n >= 2000) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge axi_clk);
    #1;
  endtask

  initial begin
    int base;
    int n;
    logic [23:0] last_sig;
    logic [7:0]  rc;
    dif.s_tdata = '0; dif.s_tvalid = 1'b0; dif.s_tlast = 1'b0; dif.s_tuser = 2'b00;
    tick(3);
    axi_reset_n = 1'b1;
    #1 chk("tready_after_rst", {31'd0, dif.s_tready}, 32'd1);
    chk("rst_data", {8'd0, dif.out_data}, 32'd0);
    tick(1);

    // Two packets back to back
    base = hs_log.size();
    send(8'd2, 24'h00005A, 1'b0, 2'b00);
    send(8'd1, 24'h0000FF, 1'b0, 2'b00);
    drain();
    chk("t1_count", hs_log.size() - base, 32'd3);
    chk("t1_d0", {8'd0, hs_log[base].d}, 32'h5A);
    chk("t1_d1", {8'd0, hs_log[base+1].d}, 32'h5A);
    chk("t1_d2", {8'd0, hs_log[base+2].d}, 32'hFF);
    chk("t1_first", {29'd0, hs_log[base].f, hs_log[base+1].f, hs_log[base+2].f}, 32'b101);

    // Backpressure pattern 1,0,1,0,1
    base = hs_log.size();
    send(8'd3, 24'h123456, 1'b0, 2'b00);
    for (int k = 0; k < 5; k++) begin
      man_rdy = (k % 2 == 0);
      @(negedge axi_clk);
      chk("t2_tready", {31'd0, dif.s_tready}, {31'd0, (k == 4)});
      @(posedge axi_clk);
      #1;
    end
    man_rdy = 1'b1;
    drain();
    chk("t2_count", hs_log.size() - base, 32'd3);
    for (int i = 0; i < 3; i++) chk("t2_data", {8'd0, hs_log[base+i].d}, 32'h123456);

    // Overflow markers between packets
    base = hs_log.size();
    send(8'd1, 24'h000001, 1'b0, 2'b00);
    send(8'd0, 24'($urandom), 1'b0, 2'b00);
    send(8'd0, 24'($urandom), 1'b1, 2'b01);
    send(8'd2, 24'h000007, 1'b0, 2'b00);
    drain();
    chk("t3_count", hs_log.size() - base, 32'd3);
    chk("t3_data", {8'd0, hs_log[base].d}, 32'h1);
    chk("t3_data7", {8'd0, hs_log[base+1].d}, 32'h7);
    chk("t3_gap", {29'd0, hs_log[base].g, hs_log[base+1].g, hs_log[base+2].g}, 32'b010);
    chk("t3_ovf_count", {16'd0, ovf_count}, 32'd2);
    chk("t3_ovf_flag", {31'd0, ovf_flag}, 32'd1);

    // tlast and tuser
    base = hs_log.size();
    send(8'd4, 24'hABCDEF, 1'b1, 2'b10);
    drain();
    chk("t4_count", hs_log.size() - base, 32'd4);
    chk("t4_last", {28'd0, hs_log[base].l, hs_log[base+1].l, hs_log[base+2].l, hs_log[base+3].l}, 32'b0001);
    for (int i = 0; i < 4; i++) chk("t4_tuser", {30'd0, hs_log[base+i].u}, 32'd2);

    // Soft clear mid-expansion
    base = hs_log.size();
    send(8'd10, 24'h00AAAA, 1'b0, 2'b00);
    n = 0;
    while ((hs_log.size() - base) < 3 && n < 100) begin
      @(posedge axi_clk);
      #1 n++;
    end
    chk("t5_reach3", hs_log.size() - base, 32'd3);
    dec_clear = 1'b1;
    tick(1);
    dec_clear = 1'b0;
    chk("t5_valid", {31'd0, dif.out_valid}, 32'd0);
    chk("t5_ovf_count", {16'd0, ovf_count}, 32'd0);
    base = hs_log.size();
    send(8'd1, 24'h000055, 1'b0, 2'b00);
    drain();
    chk("t5_count", hs_log.size() - base, 32'd1);
    chk("t5_smp", {3'd0, hs_log[base]}, {3'd0, 24'h000055, 1'b1, 1'b0, 1'b0, 2'b00});

    // Async reset during expansion
    send(8'd255, 24'h000001, 1'b0, 2'b00);
    tick(3);
    axi_reset_n = 1'b0;
    #1;
    chk("t6_valid", {31'd0, dif.out_valid}, 32'd0);
    chk("t6_data", {8'd0, dif.out_data}, 32'd0);
    chk("t6_tready", {31'd0, dif.s_tready}, 32'd0);
    chk("t6_flags", {28'd0, dif.out_first, dif.out_gap, dif.out_last, ovf_flag}, 32'd0);
    tick(2);
    axi_reset_n = 1'b1;
    tick(1);
    base = hs_log.size();
    send(8'd255, 24'h000001, 1'b0, 2'b00);
    drain();
    chk("t6_count", hs_log.size() - base, 32'd255);

    // Randomized traffic with random backpressure and occasional clears
    rdy_rand = 1'b1;
    last_sig = 24'h0;
    for (int p = 0; p < 300; p++) begin
      n = $urandom_range(0, 9);
      if (n == 0) rc = 8'd0;
      else if (n == 1) rc = 8'($urandom_range(100, 255));
      else rc = 8'($urandom_range(1, 6));
      if ($urandom_range(0, 1) == 0) last_sig = 24'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        dec_clear = 1'b1;
        tick(1);
        dec_clear = 1'b0;
      end
      send(rc, last_sig, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 4) == 0) tick($urandom_range(1, 3));
    end
    drain();
    rdy_rand = 1'b0;
    tick(2);
    chk("final_empty", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
